// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Eight 4-byte blocks sit between the CPU load/store path and data memory.
// Hits are served with no stall. A miss writes back a dirty victim, fetches
// the block, installs it and then retries the access in IDLE.
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters.
module dcache_controller #(
  parameter int ADDR_WIDTH = 8,
  parameter int INDEX_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [7:0]            writedata,
  output logic [7:0]            readdata,
  output logic                  busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-3:0] mem_address,
  output logic [31:0]           mem_writedata,
  input  logic [31:0]           mem_readdata,
  input  logic                  mem_busywait
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int NUM_BLOCKS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FETCH  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Cache storage. Data and tags need no reset: a cleared valid bit hides them.
  logic [31:0]           data_reg  [NUM_BLOCKS];
  logic [TAG_BITS-1:0]   tag_reg   [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_reg;
  logic [NUM_BLOCKS-1:0] dirty_reg;

  // The fetched block is captured on the edge that completes the transfer. As a
  // result, memory does not have to hold its read data into the UPDATE cycle.
  logic [31:0] fill_reg;

  logic [TAG_BITS-1:0]   addr_tag;
  logic [INDEX_BITS-1:0] addr_index;
  logic [1:0]            addr_offset;
  logic [31:0]           cur_block;
  logic [7:0]            block_bytes [4];
  logic                  hit;
  logic                  req;
  logic                  in_idle;
  logic                  wr_hit;
  logic                  busy_int;

  assign addr_tag    = address[ADDR_WIDTH-1 -: TAG_BITS];
  assign addr_index  = address[2 +: INDEX_BITS];
  assign addr_offset = address[1:0];
  assign cur_block   = data_reg[addr_index];
  assign hit         = valid_reg[addr_index] && (tag_reg[addr_index] == addr_tag);
  assign req         = read | write;
  assign in_idle     = (state_reg == IDLE);
  // A combined READ and WRITE request is handled as a store.
  assign wr_hit      = reset && in_idle && write && hit;

  // Split the addressed block into byte lanes for the load mux.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign block_bytes[gi] = cur_block[8*gi +: 8];
  end

  // Load data is only presented for a read hit. Otherwise it is held at zero.
  assign readdata = (reset && in_idle && read && !write && hit) ?
                    block_bytes[addr_offset] : 8'h00;

  // CPU stall is forced low while reset is asserted, even with a request pending.
  assign busywait = reset && busy_int;

  // State register. Reset abandons any memory transfer that is in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and the memory-side request outputs.
  always_comb begin
    state_next    = state_reg;
    busy_int      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = 32'h0;
    case (state_reg)
      IDLE: begin
        if (req && !hit) begin
          busy_int   = 1'b1;
          state_next = dirty_reg[addr_index] ? WB : FETCH;
        end
      end
      WB: begin
        busy_int      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {tag_reg[addr_index], addr_index};
        mem_writedata = cur_block;
        if (!mem_busywait) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        busy_int    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {addr_tag, addr_index};
        if (!mem_busywait) begin
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        busy_int   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the fetched block when the memory read completes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_reg <= 32'h0;
    end else if (state_reg == FETCH && !mem_busywait) begin
      fill_reg <= mem_readdata;
    end
  end

  // Cache array writes. UPDATE installs a clean block, and a write hit dirties one byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (state_reg == UPDATE) begin
      data_reg[addr_index]  <= fill_reg;
      tag_reg[addr_index]   <= addr_tag;
      valid_reg[addr_index] <= 1'b1;
      dirty_reg[addr_index] <= 1'b0;
    end else if (wr_hit) begin
      data_reg[addr_index][{addr_offset, 3'b000} +: 8] <= writedata;
      dirty_reg[addr_index] <= 1'b1;
    end
  end

`ifdef CACHE_STATS_EN
  logic hit_evt;
  logic miss_evt;
  logic [15:0] hit_count_reg;
  logic [15:0] miss_count_reg;

  // Every IDLE cycle that holds a request is either a completed hit or a miss start.
  assign hit_evt  = in_idle && req && hit;
  assign miss_evt = in_idle && req && !hit;

  // Saturating access counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_count_reg  <= 16'h0;
      miss_count_reg <= 16'h0;
    end else begin
      if (hit_evt && hit_count_reg != 16'hFFFF) begin
        hit_count_reg <= hit_count_reg + 16'd1;
      end
      if (miss_evt && miss_count_reg != 16'hFFFF) begin
        miss_count_reg <= miss_count_reg + 16'd1;
      end
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed testbench for dcache_controller. The bench drives the memory
// handshake directly and checks the outputs against hand-computed values.
// The stats checks run only when CACHE_STATS_EN is defined.
module tb_dcache_controller;

  logic        clk;
  logic        reset;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int compared;
  int mismatched;

  dcache_controller #(.ADDR_WIDTH(8), .INDEX_BITS(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef CACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge. Checks are taken 1 unit
  // later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    reset        = 1'b0;
    read         = 1'b0;
    write        = 1'b0;
    address      = 8'h00;
    writedata    = 8'h00;
    mem_readdata = 32'h0;
    mem_busywait = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_busywait", {31'b0, busywait}, 32'h0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
    chk("rst_readdata", {24'b0, readdata}, 32'h0);
    chk("rst_mem_address", {26'b0, mem_address}, 32'h0);
    chk("rst_mem_writedata", mem_writedata, 32'h0);

    // Clean cold miss on address 0x00
    reset        = 1'b1;
    read         = 1'b1;
    address      = 8'h00;
    mem_readdata = 32'h44332211;
    #1;
    chk("miss0_idle_busywait", {31'b0, busywait}, 32'h1);
    chk("miss0_idle_mem_read", {31'b0, mem_read}, 32'h0);
    tick();
    chk("miss0_fetch_mem_read", {31'b0, mem_read}, 32'h1);
    chk("miss0_fetch_mem_write", {31'b0, mem_write}, 32'h0);
    chk("miss0_fetch_addr", {26'b0, mem_address}, 32'h00);
    chk("miss0_fetch_busywait", {31'b0, busywait}, 32'h1);
    tick();
    chk("miss0_update_busywait", {31'b0, busywait}, 32'h1);
    chk("miss0_update_mem_read", {31'b0, mem_read}, 32'h0);
    tick();
    chk("miss0_retry_busywait", {31'b0, busywait}, 32'h0);
    chk("miss0_retry_readdata", {24'b0, readdata}, 32'h11);

    // Read hits on the remaining bytes of the filled block
    address = 8'h01;
    #1;
    chk("hit1_readdata", {24'b0, readdata}, 32'h22);
    chk("hit1_busywait", {31'b0, busywait}, 32'h0);
    tick();
    address = 8'h02;
    #1;
    chk("hit2_readdata", {24'b0, readdata}, 32'h33);
    chk("hit2_mem_read", {31'b0, mem_read}, 32'h0);
    tick();
    address = 8'h03;
    #1;
    chk("hit3_readdata", {24'b0, readdata}, 32'h44);
    chk("hit3_busywait", {31'b0, busywait}, 32'h0);
    tick();

    // Write hit on byte 2. The block becomes dirty.
    read      = 1'b0;
    write     = 1'b1;
    address   = 8'h02;
    writedata = 8'hAA;
    #1;
    chk("whit_busywait", {31'b0, busywait}, 32'h0);
    tick();
    write = 1'b0;

    // Conflict miss on 0x22: tag 1, index 0, offset 2. The dirty victim is written back.
    read         = 1'b1;
    address      = 8'h22;
    mem_readdata = 32'hDDCCBBEE;
    #1;
    chk("dmiss_idle_busywait", {31'b0, busywait}, 32'h1);
    chk("dmiss_idle_readdata", {24'b0, readdata}, 32'h0);
    tick();
    chk("dmiss_wb_mem_write", {31'b0, mem_write}, 32'h1);
    chk("dmiss_wb_mem_read", {31'b0, mem_read}, 32'h0);
    chk("dmiss_wb_addr", {26'b0, mem_address}, 32'h00);
    chk("dmiss_wb_data", mem_writedata, 32'h44AA2211);
    tick();
    chk("dmiss_fetch_mem_read", {31'b0, mem_read}, 32'h1);
    chk("dmiss_fetch_mem_write", {31'b0, mem_write}, 32'h0);
    chk("dmiss_fetch_addr", {26'b0, mem_address}, 32'h08);
    tick();
    chk("dmiss_update_busywait", {31'b0, busywait}, 32'h1);
    tick();
    chk("dmiss_retry_busywait", {31'b0, busywait}, 32'h0);
    chk("dmiss_retry_readdata", {24'b0, readdata}, 32'hCC);

    // Clean miss back to 0x02 while memory stays busy for 5 cycles
    address      = 8'h02;
    mem_readdata = 32'h44AA2211;
    mem_busywait = 1'b1;
    #1;
    chk("slow_idle_busywait", {31'b0, busywait}, 32'h1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("slow_wait%0d_busywait", i), {31'b0, busywait}, 32'h1);
      chk($sformatf("slow_wait%0d_mem_read", i), {31'b0, mem_read}, 32'h1);
      chk($sformatf("slow_wait%0d_readdata", i), {24'b0, readdata}, 32'h0);
      tick();
    end
    mem_busywait = 1'b0;
    #1;
    chk("slow_release_mem_read", {31'b0, mem_read}, 32'h1);
    tick();
    chk("slow_update_busywait", {31'b0, busywait}, 32'h1);
    tick();
    chk("slow_retry_busywait", {31'b0, busywait}, 32'h0);
    chk("slow_retry_readdata", {24'b0, readdata}, 32'hAA);

    // Reset asserted during FETCH of 0x40 (tag 2, index 0, clean victim)
    address      = 8'h40;
    mem_readdata = 32'h0BADF00D;
    tick();
    chk("rstf_fetch_mem_read", {31'b0, mem_read}, 32'h1);
    chk("rstf_fetch_addr", {26'b0, mem_address}, 32'h10);
    mem_busywait = 1'b1;
    reset        = 1'b0;
    tick();
    chk("rstf_after_mem_read", {31'b0, mem_read}, 32'h0);
    chk("rstf_after_busywait", {31'b0, busywait}, 32'h0);
    chk("rstf_after_readdata", {24'b0, readdata}, 32'h0);
    reset        = 1'b1;
    mem_busywait = 1'b0;
    address      = 8'h00;
    mem_readdata = 32'h44AA2211;
    #1;
    chk("rstf_remiss_busywait", {31'b0, busywait}, 32'h1);
    tick();
    chk("rstf_remiss_fetch_addr", {26'b0, mem_address}, 32'h00);
    chk("rstf_remiss_mem_write", {31'b0, mem_write}, 32'h0);
    tick();
    tick();
    chk("rstf_retry_readdata", {24'b0, readdata}, 32'h11);

    // Separate index: a write miss on 0x1D (index 7, offset 1) allocates, then stores
    read         = 1'b0;
    write        = 1'b1;
    address      = 8'h1D;
    writedata    = 8'h5A;
    mem_readdata = 32'h87654321;
    tick();
    chk("wmiss_fetch_addr", {26'b0, mem_address}, 32'h07);
    tick();
    tick();
    chk("wmiss_retry_busywait", {31'b0, busywait}, 32'h0);
    tick();
    write   = 1'b0;
    read    = 1'b1;
    #1;
    chk("wmiss_readback", {24'b0, readdata}, 32'h5A);
    address = 8'h1E;
    #1;
    chk("wmiss_neighbour", {24'b0, readdata}, 32'h65);

`ifdef CACHE_STATS_EN
    // 1 miss followed by 3 more hits. The post-fill retry is also a hit.
    read  = 1'b0;
    reset = 1'b0;
    tick();
    chk("stats_rst_hit", {16'b0, hit_count}, 32'h0);
    chk("stats_rst_miss", {16'b0, miss_count}, 32'h0);
    reset        = 1'b1;
    read         = 1'b1;
    address      = 8'h00;
    mem_readdata = 32'h44332211;
    tick();
    tick();
    tick();
    tick();
    address = 8'h01;
    tick();
    address = 8'h02;
    tick();
    address = 8'h03;
    tick();
    read = 1'b0;
    tick();
    chk("stats_miss_count", {16'b0, miss_count}, 32'h1);
    chk("stats_hit_count", {16'b0, hit_count}, 32'h4);
`endif

    read = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
